// File: rtl/data_break_arb.sv
// Data-break (DMA) arbiter: two requesters steal memory cycles from the CPU at
// break points, with round-robin tie-break and a burst limit under contention.
module data_break_arb #(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        cpu_break_ok,
  output logic        cpu_hold,
  input  logic [1:0]  req,
  input  logic [1:0]  rd,
  input  logic [1:0]  wr,
  input  logic [14:0] addr0,
  input  logic [14:0] addr1,
  input  logic [11:0] din0,
  input  logic [11:0] din1,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic [11:0] dout,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [11:0] mem_rdata,
  output logic        protocol_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ACCESS,
    S_WAIT,
    S_DONE,
    S_NEXT
  } state_t;

  state_t      state_q, state_d;
  logic        w_q, w_d;
  logic        last_q, last_d;
  logic [3:0]  burst_q, burst_d;
  logic [2:0]  lat_q, lat_d;
  logic        hold_q, hold_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        is_rd_q, is_rd_d;
  logic        err_q, err_d;
  logic [11:0] dout_q, dout_d;
  logic [14:0] maddr_q, maddr_d;
  logic [11:0] mwd_q, mwd_d;

  logic [14:0] addr_w;
  logic [11:0] din_w;
  logic        rd_w, wr_w, oth, sel;

  always_comb begin
    addr_w = w_q ? addr1 : addr0;
    din_w  = w_q ? din1 : din0;
    rd_w   = rd[w_q];
    wr_w   = wr[w_q];
    oth    = ~w_q;
    // Lone requester wins; on a tie, the one not served last goes first.
    sel    = (req == 2'b11) ? ~last_q : req[1];
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    last_d  = last_q;
    burst_d = burst_q;
    lat_d   = lat_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    is_rd_d = is_rd_q;
    err_d   = err_q;
    dout_d  = dout_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    ack     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req != '0) begin
          hold_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (req == '0) begin
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cpu_break_ok) begin
          w_d     = sel;
          gnt_d   = sel ? 2'b10 : 2'b01;
          burst_d = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_re  = rd_w & ~wr_w;
        mem_we  = wr_w & ~rd_w;
        maddr_d = addr_w;
        mwd_d   = din_w;
        is_rd_d = rd_w & ~wr_w;
        if (rd_w == wr_w) err_d = 1'b1;
        lat_d   = 3'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          if (is_rd_q) dout_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ack = gnt_q;
        if (burst_q != 4'hf) burst_d = burst_q + 4'd1;
        last_d  = w_q;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (req[w_q] && (!req[oth] || burst_q < 4'(MAX_BURST))) begin
          state_d = S_ACCESS;
        end else if (req[oth]) begin
          w_d     = oth;
          gnt_d   = oth ? 2'b10 : 2'b01;
          burst_d = '0;
          state_d = S_ACCESS;
        end else begin
          gnt_d   = '0;
          hold_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= S_IDLE;
      w_q     <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      lat_q   <= '0;
      hold_q  <= 1'b0;
      gnt_q   <= '0;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      maddr_q <= '0;
      mwd_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      lat_q   <= lat_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      is_rd_q <= is_rd_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
    end
  end

  // Address/data follow the winner during ACCESS and hold their last value otherwise.
  assign mem_addr     = maddr_d;
  assign mem_wdata    = mwd_d;
  assign cpu_hold     = hold_q;
  assign gnt          = gnt_q;
  assign dout         = dout_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_data_break_arb.sv
// Self-checking bench for data_break_arb: cycle tables, directed corner
// sequences, and randomized traffic against a transaction-timeline model.
module tb_data_break_arb;

  localparam int LAT  = 1;
  localparam int MAXB = 2;

  localparam logic [14:0] A0  = 15'o10200;
  localparam logic [14:0] A1  = 15'o01234;
  localparam logic [11:0] D0  = 12'o1234;
  localparam logic [11:0] D1  = 12'o7777;
  localparam logic [11:0] RD1 = 12'o4321;
  localparam logic [11:0] RD2 = 12'o0555;

  logic        clk = 1'b0;
  logic        reset, clear, cpu_break_ok, cpu_hold;
  logic [1:0]  req, rd, wr, gnt, ack;
  logic [14:0] addr0, addr1, mem_addr;
  logic [11:0] din0, din1, dout, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, protocol_err;

  data_break_arb #(.MEM_LAT(LAT), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .clear(clear), .cpu_break_ok(cpu_break_ok),
    .cpu_hold(cpu_hold), .req(req), .rd(rd), .wr(wr),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .gnt(gnt), .ack(ack), .dout(dout), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; cpu_break_ok = 1'b0;
    req = '0; rd = '0; wr = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i != 0) ? 2'b10 : 2'b01;
  endfunction

  typedef struct {
    logic [1:0]  req, rd, wr;
    logic        brk;
    logic [11:0] rdat;
    logic        hold;
    logic [1:0]  gnt, ack;
    logic        re, we;
    logic [14:0] maddr;
    logic [11:0] mwd, dq;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic [1:0] rq, input logic [1:0] r, input logic [1:0] w,
                         input logic b, input logic [11:0] rdt, input logic h,
                         input logic [1:0] g, input logic [1:0] a, input logic re,
                         input logic we, input logic [14:0] ma, input logic [11:0] mw,
                         input logic [11:0] dq);
    vec_t v;
    v.req = rq; v.rd = r; v.wr = w; v.brk = b; v.rdat = rdt;
    v.hold = h; v.gnt = g; v.ack = a; v.re = re; v.we = we;
    v.maddr = ma; v.mwd = mw; v.dq = dq;
    tbl.push_back(v);
  endtask

  // Random-phase model state
  logic [11:0] tmem [16];
  int          mode, w, last_srv, run, acc_cyc, nmode, acks_seen, last_ack;
  logic        e_hold, e_re, e_we, e_err, err_pend, cur_is_rd;
  logic [1:0]  e_gnt, e_ack;
  logic [14:0] e_maddr;
  logic [11:0] e_mwd, e_dout, rd_val;
  int          order_exp [6] = '{0, 0, 1, 1, 0, 0};

  task automatic new_op(input int i);
    int k;
    k = $urandom_range(0, 15);
    if (k == 0)      begin rd[i] = 1'b1; wr[i] = 1'b1; end
    else if (k == 1) begin rd[i] = 1'b0; wr[i] = 1'b0; end
    else if (k < 9)  begin rd[i] = 1'b1; wr[i] = 1'b0; end
    else             begin rd[i] = 1'b0; wr[i] = 1'b1; end
    if (i == 0) begin addr0 = 15'($urandom); din0 = 12'($urandom); end
    else        begin addr1 = 15'($urandom); din1 = 12'($urandom); end
  endtask

  initial begin
    addr0 = A0; addr1 = A1; din0 = D0; din1 = D1; mem_rdata = RD1;

    // ---- cycle tables: single read, then write held off by the CPU ----
    add_row(2'b01, 2'b01, 2'b00, 1'b1, RD1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 15'o0, 12'o0, 12'o0);
    add_row(2'b01, 2'b01, 2'b00, 1'b1, RD1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 15'o0, 12'o0, 12'o0);
    add_row(2'b01, 2'b01, 2'b00, 1'b1, RD1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, A0, D0, 12'o0);
    add_row(2'b01, 2'b01, 2'b00, 1'b1, RD1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, A0, D0, 12'o0);
    add_row(2'b01, 2'b01, 2'b00, 1'b1, RD1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, A0, D0, RD1);
    add_row(2'b00, 2'b00, 2'b00, 1'b1, RD1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, A0, D0, RD1);
    add_row(2'b10, 2'b00, 2'b10, 1'b0, RD1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, A0, D0, RD1);
    for (int i = 0; i < 4; i++)
      add_row(2'b10, 2'b00, 2'b10, 1'b0, RD1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, A0, D0, RD1);
    add_row(2'b10, 2'b00, 2'b10, 1'b1, RD1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, A0, D0, RD1);
    add_row(2'b10, 2'b00, 2'b10, 1'b1, RD1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, A1, D1, RD1);
    add_row(2'b10, 2'b00, 2'b10, 1'b1, RD2, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, A1, D1, RD1);
    add_row(2'b10, 2'b00, 2'b10, 1'b1, RD2, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, A1, D1, RD1);
    add_row(2'b00, 2'b00, 2'b00, 1'b1, RD2, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, A1, D1, RD1);
    add_row(2'b00, 2'b00, 2'b00, 1'b1, RD2, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, A1, D1, RD1);

    do_reset();
    chk("reset_ctl", {cpu_hold, gnt, ack, mem_re, mem_we, protocol_err}, '0);
    chk("reset_data", {mem_addr, mem_wdata}, '0);
    chk("reset_dout", dout, '0);

    foreach (tbl[i]) begin
      req = tbl[i].req; rd = tbl[i].rd; wr = tbl[i].wr;
      cpu_break_ok = tbl[i].brk; mem_rdata = tbl[i].rdat;
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), {cpu_hold, gnt, ack, mem_re, mem_we},
          {tbl[i].hold, tbl[i].gnt, tbl[i].ack, tbl[i].re, tbl[i].we});
      chk($sformatf("tbl%0d_maddr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("tbl%0d_mwdata", i), mem_wdata, tbl[i].mwd);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dq);
      next_cycle();
    end

    // ---- contention + tie after reset: order 0,0,1,1,0,0, spacing LAT+3 ----
    do_reset();
    req = 2'b11; rd = 2'b11; wr = 2'b00; cpu_break_ok = 1'b1;
    acks_seen = 0; last_ack = -1;
    for (int c = 0; c < 60 && acks_seen < 6; c++) begin
      mem_rdata = 12'($urandom);
      @(negedge clk);
      if (c >= 1) chk("contend_hold", cpu_hold, 1'b1);
      chk("contend_onehot", $onehot0(gnt), 1'b1);
      if (ack != '0) begin
        chk("contend_ack_gnt", ack, gnt);
        chk($sformatf("contend_order%0d", acks_seen), ack[1], order_exp[acks_seen][0]);
        if (acks_seen == 0) chk("contend_first", c, 3 + LAT);
        else                chk("contend_spacing", c - last_ack, LAT + 3);
        last_ack = c;
        acks_seen++;
      end
      next_cycle();
    end
    chk("contend_count", acks_seen, 6);
    req = '0;
    for (int c = 0; c < 4; c++) next_cycle();

    // ---- protocol error: rd and wr both set ----
    do_reset();
    req = 2'b01; rd = 2'b01; wr = 2'b01; cpu_break_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("perr_gnt", gnt, 2'b01);
        chk("perr_strobes", {mem_re, mem_we}, 2'b00);
        chk("perr_not_yet", protocol_err, 1'b0);
      end
      if (c == 3) chk("perr_set", protocol_err, 1'b1);
      if (c == 4) chk("perr_ack", ack, 2'b01);
      if (c == 9) chk("perr_sticky", protocol_err, 1'b1);
      next_cycle();
      if (c == 4) req = '0;
    end
    do_reset();
    @(negedge clk);
    chk("perr_cleared", protocol_err, 1'b0);
    next_cycle();

    // ---- abort: clear mid-WAIT ----
    do_reset();
    req = 2'b01; rd = 2'b01; wr = 2'b00; cpu_break_ok = 1'b1; mem_rdata = 12'o6543;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) chk("abort_access_re", mem_re, 1'b1);
      next_cycle();
    end
    clear = 1'b1;
    @(negedge clk);
    chk("abort_in_wait", gnt, 2'b01);
    next_cycle();
    clear = 1'b0; req = '0;
    @(negedge clk);
    chk("abort_idle", {cpu_hold, gnt, ack}, '0);
    chk("abort_dout", dout, '0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      chk("abort_no_ack", {cpu_hold, ack}, '0);
    end
    next_cycle();

    // ---- randomized traffic against timeline model ----
    for (int i = 0; i < 16; i++) tmem[i] = 12'($urandom);
    do_reset();
    mode = 0; w = 0; last_srv = 1; run = 0; acc_cyc = -100;
    e_dout = '0; e_maddr = '0; e_mwd = '0; e_err = 1'b0; err_pend = 1'b0;
    cur_is_rd = 1'b0; rd_val = '0;
    mem_rdata = 12'($urandom);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (err_pend) e_err = 1'b1;
      err_pend = 1'b0;
      e_re = 1'b0; e_we = 1'b0; e_ack = '0; e_gnt = '0; e_hold = 1'b0;
      nmode = mode;
      if (mode == 0) begin
        if (req != '0) nmode = 1;
      end else if (mode == 1) begin
        e_hold = 1'b1;
        if (req == '0) nmode = 0;
        else if (cpu_break_ok) begin
          w = (req == 2'b11) ? 1 - last_srv : int'(req[1]);
          run = 0; acc_cyc = c + 1; nmode = 2;
        end
      end else begin
        e_hold = 1'b1;
        e_gnt = oh(w);
        if (c == acc_cyc) begin
          e_re = rd[w] & ~wr[w];
          e_we = wr[w] & ~rd[w];
          if (rd[w] == wr[w]) err_pend = 1'b1;
          e_maddr = (w != 0) ? addr1 : addr0;
          e_mwd   = (w != 0) ? din1 : din0;
          cur_is_rd = e_re;
          if (e_re) rd_val = tmem[e_maddr[3:0]];
          if (e_we) tmem[e_maddr[3:0]] = e_mwd;
        end
        if (c == acc_cyc + LAT + 1) begin
          e_ack = oh(w);
          if (cur_is_rd) e_dout = rd_val;
          if (run < 15) run++;
          last_srv = w;
        end
        if (c == acc_cyc + LAT + 2) begin
          if (req[w] && (!req[1 - w] || run < MAXB)) acc_cyc = c + 1;
          else if (req[1 - w]) begin w = 1 - w; run = 0; acc_cyc = c + 1; end
          else nmode = 0;
        end
      end
      mode = nmode;
      chk("rnd_ctl", {cpu_hold, gnt, ack, mem_re, mem_we}, {e_hold, e_gnt, e_ack, e_re, e_we});
      chk("rnd_maddr", mem_addr, e_maddr);
      chk("rnd_mwdata", mem_wdata, e_mwd);
      chk("rnd_dout", dout, e_dout);
      chk("rnd_perr", protocol_err, e_err);

      next_cycle();
      if (mode == 2 && cur_is_rd && c >= acc_cyc && c + 1 <= acc_cyc + LAT)
        mem_rdata = rd_val;
      else
        mem_rdata = 12'($urandom);
      cpu_break_ok = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            new_op(i);
            req[i] = 1'b1;
          end
        end else if (e_ack[i]) begin
          if ($urandom_range(0, 1) == 0) new_op(i);
          else req[i] = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
